// File: rtl/spi_counter_master.sv
// SPI master for a frequency-counter responder: loads a gate count, waits for the
// responder's done flag (or a timeout), then reads back the 56-bit count word.
module spi_counter_master #(
    parameter int          CLK_DIV   = 16,
    parameter int          SS_GUARD  = 16,
    parameter int          INT_BLANK = 64,
    parameter logic [31:0] TIMEOUT   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] gate_count,
    output logic        busy,
    output logic        result_valid,
    output logic [39:0] result_upcount,
    output logic [15:0] result_downcount,
    output logic        result_timeout,
    output logic        start_error,
    output logic        SCK,
    output logic        SS,
    output logic        SDO,
    input  logic        SDI,
    input  logic        FPGA_INT
);
    typedef enum logic [3:0] {
        IDLE, LOAD_SETUP, LOAD_SHIFT, LOAD_HOLD, WAIT_INT,
        READ_SETUP, READ_SHIFT, READ_HOLD, DONE
    } state_t;

    localparam logic [31:0] HALF_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] GUARD_LAST = 32'(SS_GUARD - 1);
    localparam logic [31:0] BLANK_END  = 32'(INT_BLANK);
    localparam logic [31:0] TMO_LAST   = TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [5:0]  bit_q, bit_d;
    logic [55:0] tx_q, tx_d;
    logic [55:0] rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        ss_q, ss_d;
    logic        flag_q, flag_d;
    logic        start_error_q, start_error_d;
    logic [39:0] up_q, up_d;
    logic [15:0] down_q, down_d;
    logic        res_tmo_q, res_tmo_d;
    logic [1:0]  sdi_sync_q, int_sync_q;
    logic [1:0]  fall_pipe_q;
    logic        fall_now;

    // NOTE: every _d signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        bit_d         = bit_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        sck_d         = sck_q;
        ss_d          = ss_q;
        flag_d        = flag_q;
        up_d          = up_q;
        down_d        = down_q;
        res_tmo_d     = res_tmo_q;
        start_error_d = 1'b0;
        fall_now      = 1'b0;

        // SDI is taken two cycles after each SCK fall, matching the synchronizer delay.
        if (state_q == READ_SHIFT && fall_pipe_q[1]) begin
            rx_d = {rx_q[54:0], sdi_sync_q[1]};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (gate_count != 16'd0) begin
                        state_d = LOAD_SETUP;
                        tx_d    = {gate_count, 40'd0};
                        ss_d    = 1'b0;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        flag_d  = 1'b0;
                    end else begin
                        start_error_d = 1'b1;
                    end
                end
            end
            LOAD_SETUP, READ_SETUP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == GUARD_LAST) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    sck_d    = 1'b0;
                    fall_now = 1'b1;
                    state_d  = (state_q == LOAD_SETUP) ? LOAD_SHIFT : READ_SHIFT;
                end
            end
            LOAD_SHIFT, READ_SHIFT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        tx_d  = {tx_q[54:0], 1'b0};
                        if (bit_q == 6'd55) begin
                            state_d = (state_q == LOAD_SHIFT) ? LOAD_HOLD : READ_HOLD;
                        end
                    end else begin
                        sck_d    = 1'b0;
                        fall_now = 1'b1;
                        bit_d    = bit_q + 6'd1;
                    end
                end
            end
            LOAD_HOLD, READ_HOLD: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == GUARD_LAST) begin
                    cnt_d = '0;
                    ss_d  = 1'b1;
                    if (state_q == LOAD_HOLD) begin
                        state_d = WAIT_INT;
                    end else begin
                        state_d   = DONE;
                        up_d      = rx_q[39:0];
                        down_d    = rx_q[55:40];
                        res_tmo_d = flag_q;
                    end
                end
            end
            WAIT_INT: begin
                if (cnt_q != BLANK_END) begin
                    cnt_d = cnt_q + 32'd1;
                end else if (int_sync_q[1] || tmo_q == TMO_LAST) begin
                    state_d = READ_SETUP;
                    flag_d  = !int_sync_q[1];
                    ss_d    = 1'b0;
                    tx_d    = '0;
                    rx_d    = '0;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tmo_q         <= '0;
            bit_q         <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            sck_q         <= 1'b1;
            ss_q          <= 1'b1;
            flag_q        <= 1'b0;
            start_error_q <= 1'b0;
            up_q          <= '0;
            down_q        <= '0;
            res_tmo_q     <= 1'b0;
            sdi_sync_q    <= '0;
            int_sync_q    <= '0;
            fall_pipe_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            bit_q         <= bit_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            sck_q         <= sck_d;
            ss_q          <= ss_d;
            flag_q        <= flag_d;
            start_error_q <= start_error_d;
            up_q          <= up_d;
            down_q        <= down_d;
            res_tmo_q     <= res_tmo_d;
            sdi_sync_q    <= {sdi_sync_q[0], SDI};
            int_sync_q    <= {int_sync_q[0], FPGA_INT};
            fall_pipe_q   <= {fall_pipe_q[0], fall_now};
        end
    end

    // SDO is the shift-register MSB, so it only moves on SCK rise or SS assert.
    assign SDO              = tx_q[55];
    assign SCK              = sck_q;
    assign SS               = ss_q;
    assign busy             = (state_q != IDLE);
    assign result_valid     = (state_q == DONE);
    assign result_upcount   = up_q;
    assign result_downcount = down_q;
    assign result_timeout   = res_tmo_q;
    assign start_error      = start_error_q;

endmodule
